// File: rtl/lzw_seq_ctrl.sv
// lzw_seq_ctrl: sequencer for the LZW path (code-RAM init, byte input, flush, output drain).
// Optional macro LZW_RX_FIFO_EN replaces the single input holding register with a 4-entry FIFO.
module lzw_seq_ctrl #(
  parameter logic [7:0] EOF_CODE   = 8'h0D,
  parameter int         MAX_BYTES  = 4096,
  parameter int         SETTLE_CYC = 10,
  parameter int         DRAIN_CYC  = 20
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_cr,
  input  logic        done_cr,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        lzw_valid,
  output logic [7:0]  lzw_data,
  input  logic        lzw_ready,
  output logic        lzw_flush,
  input  logic        lzw_done,
  input  logic        out_busy,
  output logic        lzw_active,
  output logic        final_done,
  output logic [12:0] byte_cnt,
  output logic        ovf_err
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, INIT = 3'd1, SETTLE = 3'd2, RUN = 3'd3,
    FLUSH = 3'd4, WAIT_LZW = 3'd5, DRAIN = 3'd6, DONE = 3'd7
  } state_t;

  localparam logic [12:0] LAST_CNT    = 13'(MAX_BYTES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYC - 1);

  state_t      state_r;
  logic [15:0] cyc_r;
  logic        eof_seen_r;
  logic        rx_run_s;
  logic        is_eof_s;
  logic        hs_s;
  logic        limit_s;
  logic        drop_s;
  logic        eof_done_s;

`ifdef LZW_RX_FIFO_EN
  // Entry bit 8 marks a queued EOF; it never drives lzw_valid.
  logic [8:0] fifo_r [4];
  logic [1:0] rd_r;
  logic [1:0] wr_r;
  logic [2:0] fcnt_r;
  logic [8:0] head_s;
  logic       eof_head_s;
  logic       pop_s;
  logic       wr_s;

  assign head_s     = fifo_r[rd_r];
  assign eof_head_s = (fcnt_r != 3'd0) && head_s[8];
  assign lzw_valid  = (fcnt_r != 3'd0) && !head_s[8];
  assign lzw_data   = head_s[7:0];
`else
  logic       full_r;
  logic [7:0] data_r;
  logic       load_s;

  assign lzw_valid = full_r;
  assign lzw_data  = data_r;
`endif

  // Input acceptance, handshake and end-of-input decode
  always_comb begin
    rx_run_s = (state_r == RUN) && rx_valid && !eof_seen_r;
    is_eof_s = (rx_data == EOF_CODE);
    hs_s     = lzw_valid && lzw_ready;
    limit_s  = hs_s && (byte_cnt == LAST_CNT);
`ifdef LZW_RX_FIFO_EN
    pop_s      = hs_s || eof_head_s;
    wr_s       = rx_run_s && ((fcnt_r != 3'd4) || pop_s);
    drop_s     = rx_run_s && !wr_s;
    eof_done_s = eof_head_s;
`else
    load_s     = rx_run_s && !is_eof_s && (!full_r || hs_s);
    drop_s     = rx_run_s && !is_eof_s && full_r && !hs_s;
    // EOF ends input only once the holding register will be empty next cycle
    eof_done_s = (eof_seen_r || (rx_run_s && is_eof_s)) && !load_s && !(full_r && !hs_s);
`endif
  end

  // Sequencer state, input storage and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cyc_r      <= 16'd0;
      eof_seen_r <= 1'b0;
      init_cr    <= 1'b0;
      lzw_flush  <= 1'b0;
      lzw_active <= 1'b0;
      final_done <= 1'b0;
      byte_cnt   <= 13'd0;
      ovf_err    <= 1'b0;
`ifdef LZW_RX_FIFO_EN
      for (int i = 0; i < 4; i++) fifo_r[i] <= 9'd0;
      rd_r   <= 2'd0;
      wr_r   <= 2'd0;
      fcnt_r <= 3'd0;
`else
      full_r <= 1'b0;
      data_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= INIT;
          init_cr <= 1'b1;
        end
        INIT: begin
          if (rx_valid) ovf_err <= 1'b1;
          if (done_cr) begin
            state_r <= SETTLE;
            init_cr <= 1'b0;
            cyc_r   <= 16'd0;
          end
        end
        SETTLE: begin
          if (rx_valid) ovf_err <= 1'b1;
          if (cyc_r == SETTLE_LAST) begin
            state_r    <= RUN;
            lzw_active <= 1'b1;
          end else begin
            cyc_r <= cyc_r + 16'd1;
          end
        end
        RUN: begin
          if (hs_s && (byte_cnt != 13'h1FFF)) byte_cnt <= byte_cnt + 13'd1;
          if (drop_s) ovf_err <= 1'b1;
`ifdef LZW_RX_FIFO_EN
          if (wr_s && is_eof_s) eof_seen_r <= 1'b1;
          if (wr_s) begin
            fifo_r[wr_r] <= {is_eof_s, rx_data};
            wr_r         <= wr_r + 2'd1;
          end
          if (pop_s) rd_r <= rd_r + 2'd1;
          fcnt_r <= fcnt_r + {2'b00, wr_s} - {2'b00, pop_s};
`else
          if (rx_run_s && is_eof_s) eof_seen_r <= 1'b1;
          if (load_s) begin
            full_r <= 1'b1;
            data_r <= rx_data;
          end else if (hs_s) begin
            full_r <= 1'b0;
          end
`endif
          // Size limit and EOF share one exit so they yield a single flush pulse
          if (limit_s || eof_done_s) begin
            state_r    <= FLUSH;
            lzw_flush  <= 1'b1;
            lzw_active <= 1'b0;
`ifdef LZW_RX_FIFO_EN
            rd_r   <= 2'd0;
            wr_r   <= 2'd0;
            fcnt_r <= 3'd0;
`else
            full_r <= 1'b0;
`endif
          end
        end
        FLUSH: begin
          lzw_flush <= 1'b0;
          state_r   <= WAIT_LZW;
        end
        WAIT_LZW: begin
          if (lzw_done) begin
            state_r <= DRAIN;
            cyc_r   <= 16'd0;
          end
        end
        DRAIN: begin
          if (out_busy) begin
            cyc_r <= 16'd0;
          end else if (cyc_r == DRAIN_LAST) begin
            state_r    <= DONE;
            final_done <= 1'b1;
          end else begin
            cyc_r <= cyc_r + 16'd1;
          end
        end
        DONE: begin
          final_done <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzw_seq_ctrl.sv
// Self-checking bench for lzw_seq_ctrl: expected LZW bytes are queued when driven and
// compared at each handshake; per-scenario tasks check sequencing and status outputs.
module tb_lzw_seq_ctrl;
  logic        clk;
  logic        rst;
  logic        init_cr;
  logic        done_cr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        lzw_valid;
  logic [7:0]  lzw_data;
  logic        lzw_ready;
  logic        lzw_flush;
  logic        lzw_done;
  logic        out_busy;
  logic        lzw_active;
  logic        final_done;
  logic [12:0] byte_cnt;
  logic        ovf_err;

  int         n_cmp = 0;
  int         n_err = 0;
  int         flush_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  lzw_seq_ctrl dut (
    .clk(clk), .rst(rst), .init_cr(init_cr), .done_cr(done_cr),
    .rx_valid(rx_valid), .rx_data(rx_data), .lzw_valid(lzw_valid), .lzw_data(lzw_data),
    .lzw_ready(lzw_ready), .lzw_flush(lzw_flush), .lzw_done(lzw_done), .out_busy(out_busy),
    .lzw_active(lzw_active), .final_done(final_done), .byte_cnt(byte_cnt), .ovf_err(ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every handshake must match the oldest expected byte
  always @(negedge clk) begin
    if (rst === 1'b1 && lzw_valid === 1'b1 && lzw_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL hs_unexpected: got byte %02h, expected none", lzw_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (lzw_data !== exp_b) begin
          n_err++;
          $display("FAIL hs_data: got %02h, expected %02h", lzw_data, exp_b);
        end
      end
    end
    if (rst === 1'b1 && lzw_flush === 1'b1) flush_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit expect_fwd);
    rx_valid = 1'b1;
    rx_data  = d;
    if (expect_fwd) exp_q.push_back(d);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    done_cr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; lzw_ready = 1'b1;
    lzw_done = 1'b0; out_busy = 1'b0; flush_cnt = 0;
    rst = 1'b0;
    #3;
    n_cmp++;
    if ({init_cr, lzw_valid, lzw_data, lzw_flush, lzw_active, final_done, byte_cnt, ovf_err} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got init_cr=%b valid=%b data=%02h flush=%b active=%b done=%b cnt=%0d ovf=%b, expected all 0",
               init_cr, lzw_valid, lzw_data, lzw_flush, lzw_active, final_done, byte_cnt, ovf_err);
    end
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (init_cr !== 1'b1) begin n_err++; $display("FAIL init_cr_rise: got %b, expected 1", init_cr); end
    repeat (4) tick();
    done_cr = 1'b1;
    tick();
    n_cmp++;
    if (init_cr !== 1'b0) begin n_err++; $display("FAIL init_cr_fall: got %b, expected 0", init_cr); end
    n = 0;
    while (lzw_active !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++;
    if (n != 10) begin n_err++; $display("FAIL settle_len: got %0d cycles, expected 10", n); end
    n_cmp++;
    if (byte_cnt !== 13'd0) begin n_err++; $display("FAIL cnt_start: got %0d, expected 0", byte_cnt); end
  endtask

  task automatic test_stream();
    int n;
    flush_cnt = 0;
    lzw_ready = 1'b1;
    for (int c = 8'h41; c <= 8'h5A; c++) send_byte(8'(c), 1'b1);
    for (int c = 8'h61; c <= 8'h7A; c++) send_byte(8'(c), 1'b1);
    send_byte(8'h0D, 1'b0);
    n = 0;
    while (flush_cnt == 0 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    n_cmp++;
    if (flush_cnt != 1) begin n_err++; $display("FAIL stream_flush: got %0d pulses, expected 1", flush_cnt); end
    n_cmp++;
    if (byte_cnt !== 13'd52) begin n_err++; $display("FAIL stream_cnt: got %0d, expected 52", byte_cnt); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_left: got %0d undelivered, expected 0", exp_q.size()); end
    n_cmp++;
    if (ovf_err !== 1'b0 || lzw_active !== 1'b0) begin
      n_err++;
      $display("FAIL stream_status: got ovf=%b active=%b, expected 0 0", ovf_err, lzw_active);
    end
  endtask

  task automatic test_drain();
    int n;
    lzw_done = 1'b1;
    out_busy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (14) tick();
      out_busy = 1'b1;
      tick();
      out_busy = 1'b0;
    end
    n_cmp++;
    if (final_done !== 1'b0) begin n_err++; $display("FAIL drain_early: got %b, expected 0", final_done); end
    n = 0;
    while (final_done !== 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++;
    if (n != 20) begin n_err++; $display("FAIL drain_len: got %0d cycles, expected 20", n); end
    repeat (5) tick();
    lzw_done = 1'b0;
    out_busy = 1'b1;
    tick();
    n_cmp++;
    if (final_done !== 1'b1) begin n_err++; $display("FAIL done_held: got %b, expected 1", final_done); end
    out_busy = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    lzw_ready = 1'b0;
    send_byte(8'h30, 1'b0);
    n_cmp++;
    if (lzw_valid !== 1'b1 || lzw_data !== 8'h30) begin
      n_err++;
      $display("FAIL mid_pending: got valid=%b data=%02h, expected 1 30", lzw_valid, lzw_data);
    end
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({init_cr, lzw_valid, lzw_data, lzw_flush, lzw_active, final_done, byte_cnt, ovf_err} !== 27'd0) begin
      n_err++;
      $display("FAIL mid_async_reset: got active=%b valid=%b data=%02h cnt=%0d, expected all 0",
               lzw_active, lzw_valid, lzw_data, byte_cnt);
    end
  endtask

  task automatic test_backpressure();
    lzw_ready = 1'b0;
    send_byte(8'h41, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx_valid = 1'b1;
        rx_data  = 8'h42;
`ifdef LZW_RX_FIFO_EN
        exp_q.push_back(8'h42);
`endif
      end
      tick();
      rx_valid = 1'b0;
      n_cmp++;
      if (lzw_valid !== 1'b1 || lzw_data !== 8'h41) begin
        n_err++;
        $display("FAIL bp_stable: cycle %0d got valid=%b data=%02h, expected 1 41", i, lzw_valid, lzw_data);
      end
    end
    n_cmp++;
`ifdef LZW_RX_FIFO_EN
    if (ovf_err !== 1'b0) begin n_err++; $display("FAIL bp_ovf: got %b, expected 0", ovf_err); end
`else
    if (ovf_err !== 1'b1) begin n_err++; $display("FAIL bp_ovf: got %b, expected 1", ovf_err); end
`endif
    lzw_ready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() != 0 || byte_cnt !== 13'(1 + exp_cnt_extra())) begin
      n_err++;
      $display("FAIL bp_deliver: got %0d left cnt=%0d", exp_q.size(), byte_cnt);
    end
  endtask

  function automatic int exp_cnt_extra();
`ifdef LZW_RX_FIFO_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic test_size_limit();
    int n;
    flush_cnt = 0;
    lzw_ready = 1'b1;
    for (int i = 0; i < 4096; i++) send_byte(8'h55, 1'b1);
    n = 0;
    while (flush_cnt == 0 && n < 50) begin tick(); n++; end
    repeat (2) tick();
    n_cmp++;
    if (byte_cnt !== 13'd4096) begin n_err++; $display("FAIL limit_cnt: got %0d, expected 4096", byte_cnt); end
    n_cmp++;
    if (flush_cnt != 1) begin n_err++; $display("FAIL limit_flush: got %0d pulses, expected 1", flush_cnt); end
    send_byte(8'h0D, 1'b0);
    repeat (3) tick();
    n_cmp++;
    if (ovf_err !== 1'b0 || lzw_valid !== 1'b0 || byte_cnt !== 13'd4096 || flush_cnt != 1) begin
      n_err++;
      $display("FAIL limit_post_eof: got ovf=%b valid=%b cnt=%0d flushes=%0d, expected 0 0 4096 1",
               ovf_err, lzw_valid, byte_cnt, flush_cnt);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL limit_left: got %0d undelivered, expected 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b0; done_cr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    lzw_ready = 1'b0; lzw_done = 1'b0; out_busy = 1'b0;
    test_reset();
    test_stream();
    test_drain();
    test_reset();
    test_reset_mid_run();
    test_reset();
    test_stream();
    test_reset();
    test_backpressure();
    test_reset();
    test_size_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lzw_seq_ctrl.md
Name: lzw_seq_ctrl

Overview:
Top-level sequencer for the LZW compression path. It performs these steps in order:
- Runs code-RAM initialisation.
- Accepts ASCII bytes from the UART receiver and forwards them to the LZW engine over a valid/ready handshake.
- Ends the input stream on EOF code or when the 4K size limit is reached, then flushes the engine.
- Waits for the output serializer to drain before raising final_done.

It sits between uart_rx, the code-RAM initialiser, the LZW core and the output serializer.

Parameters:
EOF_CODE, 8'h0D, byte value that terminates input; consumed here, never forwarded.
MAX_BYTES, 4096, input byte count that forces a flush.
SETTLE_CYC, 10, idle cycles after done_cr before accepting input.
DRAIN_CYC, 20, consecutive cycles with out_busy low required before final_done.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
init_cr  out  1  code-RAM init request, level
done_cr  in  1  code-RAM init complete, level
rx_valid  in  1  one-cycle strobe, received byte valid
rx_data  in  8  received byte
lzw_valid  out  1  byte available to LZW core
lzw_data  out  8  byte to LZW core
lzw_ready  in  1  LZW core accepts byte when lzw_valid and lzw_ready are both high
lzw_flush  out  1  one-cycle pulse: end of input, emit final code
lzw_done  in  1  LZW core finished, level
out_busy  in  1  output serializer busy
lzw_active  out  1  high in RUN
final_done  out  1  compression and output complete, held
byte_cnt  out  13  bytes accepted by LZW core
ovf_err  out  1  sticky: an input byte was dropped

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; holding register empty; counters 0.
- IDLE: unconditional transition to INIT on the next cycle.
- INIT: init_cr=1. On done_cr=1, go to SETTLE and clear init_cr in the same cycle.
- SETTLE: count SETTLE_CYC cycles, then go to RUN.
- RUN: lzw_active=1.
  - rx_valid with rx_data!=EOF_CODE loads the 8-bit holding register, which drives lzw_valid/lzw_data.
  - lzw_data stays stable while lzw_valid=1 and lzw_ready=0.
  - On handshake: holding register empties and byte_cnt increments (13-bit, saturating; no wrap).
  - Capture and handshake in the same cycle: the new byte is loaded and lzw_valid stays 1.
- EOF in RUN: on rx_valid with rx_data==EOF_CODE, stop accepting input.
  - Any pending held byte is still delivered first.
  - Then enter FLUSH; EOF is never forwarded.
- Size limit: when byte_cnt reaches MAX_BYTES on a handshake, enter FLUSH the next cycle. This applies even if EOF never arrives.
- FLUSH: lzw_flush=1 for exactly one cycle, then go to WAIT_LZW.
- WAIT_LZW: wait for lzw_done=1, then go to DRAIN.
- DRAIN: count consecutive cycles with out_busy=0. Any out_busy=1 clears the count. At DRAIN_CYC, go to DONE.
- DONE: final_done=1, held until reset. Only reset restarts the block.
- Dropped bytes:
  - rx_valid in INIT or SETTLE: byte dropped, ovf_err=1.
  - rx_valid in RUN while the holding register is full and not handshaking this cycle: byte dropped, ovf_err=1.
  - rx_valid in FLUSH, WAIT_LZW, DRAIN or DONE: byte discarded, no error.
- Simultaneous EOF and MAX_BYTES: a single FLUSH, single lzw_flush pulse.
- done_cr already high on entering INIT: INIT lasts exactly 1 cycle.
- Reset asserted mid-operation: immediate return to the reset state above. Any in-flight byte is lost.

Optional Feature:
LZW_RX_FIFO_EN
- Defined: the holding register becomes a 4-entry FIFO. ovf_err is set only on a write to a full FIFO. EOF is queued behind data and handled when it reaches the FIFO head. FLUSH waits for the FIFO to be empty.
- Undefined: single holding register, behaviour as in Behaviour.

Test Plan:
- Reset release; done_cr rises 5 cycles after init_cr -> init_cr low the same cycle; lzw_active high 10 cycles later; byte_cnt=0.
- Send 0x41..0x5A, 0x61..0x7A, then 0x0D, with lzw_ready=1 -> 52 bytes forwarded in order; byte_cnt=52; exactly one lzw_flush; 0x0D never on lzw_data.
- lzw_ready held low 8 cycles with 0x41 pending -> lzw_data stable at 0x41. A second rx_valid in that window -> ovf_err=1 (without FIFO); no ovf_err (with LZW_RX_FIFO_EN).
- Send 4096 bytes of 0x55, no EOF -> byte_cnt=4096; lzw_flush pulses once; a following 0x0D is discarded with no error.
- lzw_done high; out_busy toggles high every 15 cycles for 3 pulses, then stays low -> final_done asserts exactly 20 cycles after the last out_busy fall.
- rst low in the middle of RUN -> all outputs 0 asynchronously. After release, init_cr reasserts and the full sequence repeats.
